int_seq_mult: RTL
=================

# int_seq_mult

Iterative radix-2 shift-add integer multiplier core for the int_mult path. It accepts one operand pair per transaction and computes the unsigned magnitude product over DATA_WIDTH cycles. It hands the product downstream to the carry adder stage in one's-complement form plus a carry-in flag, so that the adder's "+carry_in" completes the two's-complement sign fix-up. One transaction is in flight at a time, with valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 32, operand width; the product is 2*DATA_WIDTH wide. Must be >= 2.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair on op_a/op_b/is_signed is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- op_a  input  DATA_WIDTH  multiplicand.
- op_b  input  DATA_WIDTH  multiplier.
- is_signed  input  1  1: both operands two's complement; 0: both unsigned.
- out_valid  output  1  prod_data/prod_neg hold a result.
- out_ready  input  1  downstream (carry adder consumer) accepts the result.
- prod_data  output  2*DATA_WIDTH  result word to the carry adder data_in. Equals the magnitude product P when prod_neg=0, and ~P (bitwise) when prod_neg=1.
- prod_neg  output  1  result is negative; drives the carry adder carry_in.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid=1, capture the following and go to BUSY with step counter=0:
    - mag_a = (is_signed & op_a[MSB]) ? ~op_a+1 : op_a, as a DATA_WIDTH-bit unsigned value. -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1), which fits.
    - mag_b, derived from op_b by the same rule.
    - neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
    - Accumulator cleared.
- **BUSY**
  - One step per cycle, operating on the register {carry, acc[DATA_WIDTH-1:0], mplr[DATA_WIDTH-1:0]}, where mplr initially holds mag_b.
  - If mplr[0]=1, then {carry, acc} = acc + mag_a.
  - The full {carry, acc, mplr} is then shifted right by 1.
  - After step DATA_WIDTH-1 (DATA_WIDTH steps total), P = {acc, mplr}. Go to DONE.
  - in_ready=0; in_valid is ignored.
- **DONE**
  - out_valid=1, prod_data = neg ? ~P : P, prod_neg = neg.
  - All outputs are held stable while out_ready=0.
  - On out_ready=1, go to IDLE and drop out_valid on that edge.
- Zero product with neg=1 gives prod_data all-ones and prod_neg=1. Downstream, ~0+1 wraps to 0 with carry_out=1. This is correct and not special-cased.
- Operands are sampled only on the accept edge; later changes on op_a/op_b have no effect.
- is_signed=0 forces neg=0 regardless of MSBs.

## Timing
- **Reset** (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, prod_data=0, prod_neg=0, counter=0, accumulator=0.
  - in_ready=1 while in IDLE, including during reset.
- **Accept:** the rising edge with in_valid=1 in IDLE.
- **Latency:** out_valid rises exactly DATA_WIDTH cycles after the accept edge.
- **Throughput:**
  - A result is consumed on an edge with out_valid=1 and out_ready=1. That edge returns the block to IDLE.
  - The next accept happens no earlier than the following edge, so the minimum period is DATA_WIDTH+2 cycles per transaction.
  - No same-cycle result handoff and new accept.
- in_ready is a Moore output (decoded from state only); no combinational path from in_valid. out_valid, prod_data and prod_neg are registered.
- **Reset mid-operation** (BUSY or DONE): the transaction is discarded with no result emitted. The block is in IDLE and ready on the first edge after rst_n deasserts.

## Test plan
- **Unsigned multiply.** DATA_WIDTH=8, is_signed=0, op_a=200, op_b=150.
  - prod_data=0x7530, prod_neg=0.
  - out_valid high exactly 8 cycles after accept.
  - in_ready=0 throughout BUSY and DONE.
- **Signed, negative result.** DATA_WIDTH=8, is_signed=1, op_a=0xFD (-3), op_b=5.
  - prod_data=0xFFF0, prod_neg=1.
  - After the carry adder: 0xFFF1 (-15).
- **Signed extremes.** DATA_WIDTH=8, is_signed=1, op_a=op_b=0x80 (-128).
  - prod_data=0x4000, prod_neg=0.
  - Repeat with op_b=0x7F: prod_data=~0x3F80=0xC07F, prod_neg=1. After the adder: 0xC080.
- **Zero product.** DATA_WIDTH=8, is_signed=1, op_a=0xF9 (-7), op_b=0.
  - prod_data=0xFFFF, prod_neg=1; the adder output is 0x0000.
  - The same operands with is_signed=0 give prod_data=0x0000, prod_neg=0.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid rises, and pulse in_valid with new operands during that window.
  - Outputs are stable and the new operands are ignored.
  - out_valid drops on the out_ready edge; in_ready is high the next cycle.
  - The next op is accepted one cycle later and its result is correct.
- **Reset mid-operation.** Assert rst_n low 4 cycles into BUSY.
  - out_valid=0, prod_data=0, prod_neg=0 immediately.
  - After deassert, 13*11 unsigned yields 0x008F with normal latency.

Source files
------------

// File: rtl/int_seq_mult_if.sv
// Handshake bundle between the operand source, the shift-add multiplier and
// the downstream carry adder.
interface int_seq_mult_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic                    is_signed;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] prod_data;
  logic                    prod_neg;

  modport master (
    output in_valid, op_a, op_b, is_signed, out_ready,
    input  in_ready, out_valid, prod_data, prod_neg
  );

  modport slave (
    input  in_valid, op_a, op_b, is_signed, out_ready,
    output in_ready, out_valid, prod_data, prod_neg
  );
endinterface

// File: rtl/int_seq_mult.sv
// Iterative radix-2 shift-add multiplier; the result goes out in one's-complement
// form plus a negate flag, and the adder's carry-in finishes the negation.
module int_seq_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  int_seq_mult_if.slave  bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DW-1:0]     r_mag_a;
  logic [DW-1:0]     r_acc;
  logic [DW-1:0]     r_mplr;
  logic              r_neg;
  logic              r_out_valid;
  logic [2*DW-1:0]   r_prod_data;
  logic              r_prod_neg;

  logic [DW-1:0]     w_mag_a;
  logic [DW-1:0]     w_mag_b;
  logic [DW:0]       w_sum;
  logic [2*DW-1:0]   w_prod;

  always_comb begin
    w_mag_a = (bus.is_signed & bus.op_a[DW-1]) ? (~bus.op_a + DW'(1)) : bus.op_a;
    w_mag_b = (bus.is_signed & bus.op_b[DW-1]) ? (~bus.op_b + DW'(1)) : bus.op_b;
    w_sum   = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mag_a} : '0);
    // Product after the last step's right shift: {carry, sum, mplr} >> 1.
    w_prod  = {w_sum, r_mplr[DW-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mag_a     <= '0;
      r_acc       <= '0;
      r_mplr      <= '0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_prod_data <= '0;
      r_prod_neg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mag_a <= w_mag_a;
            r_mplr  <= w_mag_b;
            r_acc   <= '0;
            r_neg   <= bus.is_signed & (bus.op_a[DW-1] ^ bus.op_b[DW-1]);
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc  <= w_sum[DW:1];
          r_mplr <= {w_sum[0], r_mplr[DW-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DW - 1)) begin
            r_out_valid <= 1'b1;
            r_prod_data <= r_neg ? ~w_prod : w_prod;
            r_prod_neg  <= r_neg;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.prod_data = r_prod_data;
  assign bus.prod_neg  = r_prod_neg;
endmodule
